// File: rtl/conv_window_reader_if.sv
// Pixel-in / window-out handshake bundle for conv_window_reader.
// The block connects to the slave modport; the pixel source and window sink use master.
interface conv_window_reader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_SIZE    = 5,
  parameter int FILTER_SIZE = 3
);
  localparam int RW = $clog2(IMG_SIZE);

  logic [DATA_WIDTH-1:0]                         data_in;
  logic                                          data_valid;
  logic                                          in_ready;
  logic                                          pad_mode;
  logic [DATA_WIDTH*FILTER_SIZE*FILTER_SIZE-1:0] win_out;
  logic                                          win_valid;
  logic                                          win_ready;
  logic [RW-1:0]                                 win_row;
  logic [RW-1:0]                                 win_col;
  logic                                          frame_done;

  modport master (
    output data_in, data_valid, pad_mode, win_ready,
    input  in_ready, win_out, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  data_in, data_valid, pad_mode, win_ready,
    output in_ready, win_out, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/conv_window_reader.sv
// Buffers one square image in raster order, then emits every FxF neighbourhood
// window in raster order with zero or replication padding at the borders.
module conv_window_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_SIZE    = 5,
  parameter int FILTER_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_window_reader_if.slave   bus
);
  localparam int RW = $clog2(IMG_SIZE);
  localparam int CW = RW + 2;
  localparam int P  = (FILTER_SIZE - 1) / 2;
  localparam logic [RW-1:0]        LAST_IDX = RW'(IMG_SIZE - 1);
  localparam logic signed [CW-1:0] MAX_S    = CW'(IMG_SIZE - 1);
  localparam logic signed [CW-1:0] P_S      = CW'(P);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ld_row_q, ld_row_d, ld_col_q, ld_col_d;
  logic [RW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic          pad_q, pad_d;
  logic          done_q, done_d;
  logic          wr_en;
  logic          in_ready_c, win_valid_c;

  logic [DATA_WIDTH-1:0] mem [IMG_SIZE][IMG_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      ld_row_q  <= '0;
      ld_col_q  <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      pad_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_row_q  <= ld_row_d;
      ld_col_q  <= ld_col_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      pad_q     <= pad_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    pad_d       = pad_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    in_ready_c  = 1'b0;
    win_valid_c = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.data_valid) begin
          wr_en = 1'b1;
          if (ld_col_q == LAST_IDX) begin
            ld_col_d = '0;
            if (ld_row_q == LAST_IDX) begin
              ld_row_d  = '0;
              state_d   = EMIT;
              pad_d     = bus.pad_mode;
              win_row_d = '0;
              win_col_d = '0;
            end else begin
              ld_row_d = ld_row_q + 1'b1;
            end
          end else begin
            ld_col_d = ld_col_q + 1'b1;
          end
        end
      end
      EMIT: begin
        win_valid_c = 1'b1;
        if (bus.win_ready) begin
          if (win_col_q == LAST_IDX) begin
            win_col_d = '0;
            if (win_row_q == LAST_IDX) begin
              win_row_d = '0;
              state_d   = LOAD;
              done_d    = 1'b1;
            end else begin
              win_row_d = win_row_q + 1'b1;
            end
          end else begin
            win_col_d = win_col_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_row_q][ld_col_q] <= bus.data_in;
  end

  // Signed offsets keep negative image coordinates distinguishable from large ones.
  logic signed [CW-1:0]  ri, ci;
  logic [RW-1:0]         rr, cc;
  logic                  oor;
  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH*FILTER_SIZE*FILTER_SIZE-1:0] win_c;

  always_comb begin
    win_c = '0;
    ri    = '0;
    ci    = '0;
    rr    = '0;
    cc    = '0;
    oor   = 1'b0;
    elem  = '0;
    for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
      for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
        ri   = signed'(CW'(win_row_q)) + signed'(CW'(r)) - P_S;
        ci   = signed'(CW'(win_col_q)) + signed'(CW'(c)) - P_S;
        oor  = ri[CW-1] || (ri > MAX_S) || ci[CW-1] || (ci > MAX_S);
        rr   = ri[CW-1] ? '0 : ((ri > MAX_S) ? LAST_IDX : ri[RW-1:0]);
        cc   = ci[CW-1] ? '0 : ((ci > MAX_S) ? LAST_IDX : ci[RW-1:0]);
        elem = (oor && !pad_q) ? '0 : mem[rr][cc];
        win_c[(r*FILTER_SIZE + c)*DATA_WIDTH +: DATA_WIDTH] = elem;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.win_valid  = win_valid_c;
  assign bus.win_out    = win_c;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench: table of windows for a 5x5/3x3 instance plus stall, gap,
// reset and 3x3/5x5 sequences.
module tb_conv_window_reader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_reader_if #(.DATA_WIDTH(8), .IMG_SIZE(5), .FILTER_SIZE(3)) bus ();
  conv_window_reader    #(.DATA_WIDTH(8), .IMG_SIZE(5), .FILTER_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  conv_window_reader_if #(.DATA_WIDTH(8), .IMG_SIZE(3), .FILTER_SIZE(5)) bus5 ();
  conv_window_reader    #(.DATA_WIDTH(8), .IMG_SIZE(3), .FILTER_SIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5));

  typedef struct packed {
    logic             pad;
    logic [2:0]       r;
    logic [2:0]       c;
    logic [0:8][7:0]  exp;
  } vec_t;

  vec_t vecs [9];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired, want DUT event", name);
  endtask

  task automatic load_frame(input logic pad, input bit gap);
    for (int i = 0; i < 25; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 8'(i + 1);
      bus.pad_mode   = pad;
      @(negedge clk);
      if (gap && i < 24) begin
        if (i == 23) chk("gap_wv_before_last", bus.win_valid, 0);
        bus.data_valid = 1'b0;
        bus.data_in    = 8'hEE;
        @(negedge clk);
      end
    end
    bus.data_valid = 1'b0;
    bus.pad_mode   = ~pad;
  endtask

  task automatic goto(input int r, input int c, output int n);
    n = 0;
    bus.win_ready = 1'b0;
    while (!(bus.win_valid === 1'b1 && bus.win_row == 3'(r) && bus.win_col == 3'(c)) && n < 60) begin
      bus.win_ready = 1'b1;
      @(negedge clk);
      bus.win_ready = 1'b0;
      n++;
    end
    if (n >= 60) bound_fail("goto");
  endtask

  task automatic drain(output int n);
    int t;
    n = 0;
    t = 0;
    bus.win_ready = 1'b1;
    while (bus.frame_done !== 1'b1 && t < 60) begin
      if (bus.win_valid) n++;
      @(negedge clk);
      t++;
    end
    bus.win_ready = 1'b0;
    chk("frame_done_hi", bus.frame_done, 1);
    @(negedge clk);
    chk("frame_done_lo", bus.frame_done, 0);
    chk("in_ready_after", bus.in_ready, 1);
  endtask

  task automatic chk_win(input string name, input logic [0:8][7:0] exp);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_e%0d", name, k), bus.win_out[k*8 +: 8], exp[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, t;

    vecs[0] = '{1'b0, 3'd0, 3'd0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd6, 8'd7}};
    vecs[1] = '{1'b0, 3'd4, 3'd4, {8'd19, 8'd20, 8'd0, 8'd24, 8'd25, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{1'b1, 3'd0, 3'd0, {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd6, 8'd6, 8'd7}};
    vecs[3] = '{1'b1, 3'd4, 3'd4, {8'd19, 8'd20, 8'd20, 8'd24, 8'd25, 8'd25, 8'd24, 8'd25, 8'd25}};
    vecs[4] = '{1'b0, 3'd2, 3'd2, {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19}};
    vecs[5] = '{1'b1, 3'd0, 3'd4, {8'd4, 8'd5, 8'd5, 8'd4, 8'd5, 8'd5, 8'd9, 8'd10, 8'd10}};
    vecs[6] = '{1'b0, 3'd0, 3'd4, {8'd0, 8'd0, 8'd0, 8'd4, 8'd5, 8'd0, 8'd9, 8'd10, 8'd0}};
    vecs[7] = '{1'b0, 3'd3, 3'd1, {8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18, 8'd21, 8'd22, 8'd23}};
    vecs[8] = '{1'b1, 3'd4, 3'd0, {8'd16, 8'd16, 8'd17, 8'd21, 8'd21, 8'd22, 8'd21, 8'd21, 8'd22}};

    rst_n = 1'b0;
    bus.data_in = '0;   bus.data_valid = 1'b0;  bus.pad_mode = 1'b0;  bus.win_ready = 1'b0;
    bus5.data_in = '0;  bus5.data_valid = 1'b0; bus5.pad_mode = 1'b0; bus5.win_ready = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst5_win_valid", bus5.win_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven windows, one frame per record
    for (int i = 0; i < 9; i++) begin
      load_frame(vecs[i].pad, 1'b0);
      goto(int'(vecs[i].r), int'(vecs[i].c), n);
      chk_win($sformatf("vec%0d", i), vecs[i].exp);
      drain(n2);
      chk($sformatf("vec%0d_count", i), n + n2, 25);
    end

    // Back-pressure at window (2,2)
    load_frame(1'b0, 1'b0);
    goto(2, 2, n);
    repeat (3) begin
      @(negedge clk);
      chk("stall_win", bus.win_out,
          {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7});
      chk("stall_col", bus.win_col, 2);
      chk("stall_row", bus.win_row, 2);
    end
    drain(n2);
    chk("stall_total", n + n2, 25);

    // Gapped load, then data_valid held high across EMIT
    load_frame(1'b0, 1'b1);
    chk("gap_wv_rise", bus.win_valid, 1);
    chk("emit_in_ready", bus.in_ready, 0);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hAA;
    repeat (2) @(negedge clk);
    chk_win("emit_dv_w00", {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd6, 8'd7});
    goto(4, 4, n);
    bus.data_valid = 1'b0;
    drain(n2);
    load_frame(1'b1, 1'b0);
    chk_win("after_dv_w00", {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd6, 8'd6, 8'd7});
    drain(n2);

    // Reset mid-EMIT at (1,3), then mid-LOAD, then a clean frame
    load_frame(1'b0, 1'b0);
    goto(1, 3, n);
    rst_n = 1'b0;
    #1;
    chk("rst_emit_wv", bus.win_valid, 0);
    chk("rst_emit_ir", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 8'h55;
      @(negedge clk);
    end
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(1'b1, 1'b0);
    chk("rst_new_row", bus.win_row, 0);
    chk("rst_new_col", bus.win_col, 0);
    chk_win("rst_new_w00", {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd6, 8'd6, 8'd7});
    goto(1, 3, n);
    chk_win("rst_new_w13", {8'd3, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15});
    drain(n2);

    // 3x3 image with a 5x5 window
    for (int i = 0; i < 9; i++) begin
      bus5.data_valid = 1'b1;
      bus5.data_in    = 8'(i + 1);
      @(negedge clk);
    end
    bus5.data_valid = 1'b0;
    chk("f5_wv", bus5.win_valid, 1);
    chk("f5_w00_e24", bus5.win_out[24*8 +: 8], 9);
    chk("f5_w00_e0", bus5.win_out[7:0], 0);
    bus5.win_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus5.win_ready = 1'b0;
    chk("f5_row", bus5.win_row, 1);
    chk("f5_col", bus5.win_col, 1);
    chk("f5_w11", bus5.win_out,
        {40'h0, 8'd0, 8'd9, 8'd8, 8'd7, 8'd0, 8'd0, 8'd6, 8'd5, 8'd4, 8'd0,
         8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 40'h0});
    bus5.win_ready = 1'b1;
    t = 0;
    while (bus5.frame_done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus5.win_ready = 1'b0;
    if (t >= 20) bound_fail("f5_frame_done");
    else chk("f5_windows", t + 4, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_reader.md
CONV_WINDOW_READER -- requirements
Module: conv_window_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have parameter IMG_SIZE, default 5, giving the square image side; legal values are 3, 5, 6 and 7.
REQ-003 The block SHALL have parameter FILTER_SIZE, default 3, giving the window side F; legal values are 3 and 5; P = (F-1)/2.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: raster-order pixel, row-major.
REQ-007 The block SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel when data_valid && in_ready.
REQ-009 The block SHALL have port pad_mode, input, 1 bit: 0 = zero padding, 1 = replication padding.
REQ-010 The block SHALL have port win_out, output, DATA_WIDTH*F*F bits: the flattened window.
REQ-011 The block SHALL have port win_valid, output, 1 bit: win_out is valid this cycle.
REQ-012 The block SHALL have port win_ready, input, 1 bit: the sink accepts the window; transfer occurs when win_valid && win_ready.
REQ-013 The block SHALL have port win_row, output, $clog2(IMG_SIZE) bits: centre row of the current window.
REQ-014 The block SHALL have port win_col, output, $clog2(IMG_SIZE) bits: centre column of the current window.
REQ-015 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last window transfers.

Function
REQ-016 The block SHALL implement a 2-state FSM with states LOAD and EMIT.
- LOAD: in_ready=1, win_valid=0.
- EMIT: in_ready=0, win_valid=1.
REQ-017 In LOAD, each accepted pixel SHALL be stored in an IMG_SIZE x IMG_SIZE buffer at (ld_row, ld_col); ld_col advances; it wraps to 0 at IMG_SIZE-1, and ld_row then increments.
REQ-018 Cycles with data_valid=0 SHALL leave the buffer and load counters unchanged; load progress SHALL persist across gaps.
REQ-019 Acceptance of pixel (IMG_SIZE-1, IMG_SIZE-1) SHALL move the FSM to EMIT on that edge, reset the load counters to 0, latch pad_mode into pad_q, and set win_row=win_col=0; win_valid is therefore high the next cycle.
REQ-020 The window element at window coordinates (r,c), with r,c in 0..F-1, SHALL occupy win_out[((r*F+c)*DATA_WIDTH) +: DATA_WIDTH] and reference image pixel (win_row+r-P, win_col+c-P).
REQ-021 Out-of-range coordinates SHALL be resolved as follows:
- pad_q=0: the element reads 0.
- pad_q=1: each coordinate is independently clamped to [0, IMG_SIZE-1], including corners.
REQ-022 Index arithmetic SHALL use signed values at least $clog2(IMG_SIZE)+2 bits wide, so that negative offsets never wrap.
REQ-023 win_out, win_row and win_col SHALL be held stable while win_valid=1 and win_ready=0.
REQ-024 On each transfer, win_col SHALL advance; on wrap from IMG_SIZE-1 to 0, win_row SHALL increment.
REQ-025 Windows SHALL be emitted in raster order, IMG_SIZE*IMG_SIZE windows per frame, at up to one per cycle.
REQ-026 The transfer of window (IMG_SIZE-1, IMG_SIZE-1) SHALL return the FSM to LOAD and pulse frame_done high for exactly the next cycle.
REQ-027 data_valid asserted during EMIT SHALL be ignored, with no buffer write and no counter change.
REQ-028 pad_mode changes during EMIT SHALL NOT affect the frame in flight, because pad_q is used.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force:
- FSM = LOAD;
- all counters = 0;
- pad_q = 0;
- win_valid = 0, frame_done = 0, in_ready = 1.
REQ-030 Buffer contents SHALL NOT require reset, and win_out is don't-care while win_valid=0.
REQ-031 Reset asserted mid-LOAD or mid-EMIT SHALL abandon the frame; after release, the next accepted pixel is pixel (0,0) of a new frame.

Verification
REQ-032 The bench SHALL cover the following directed scenarios (IMG_SIZE=5, F=3 unless stated, pixels 1..25 loaded, win_out listed as elements 0..8):
- pad_mode=0: window (0,0) = [0,0,0,0,1,2,0,6,7]; window (4,4) = [19,20,0,24,25,0,0,0,0].
- pad_mode=1: window (0,0) = [1,1,2,1,1,2,6,6,7]; window (4,4) = [19,20,20,24,25,25,24,25,25].
- win_ready held low for 3 cycles at window (2,2): win_out stays [7,8,9,12,13,14,17,18,19] and win_col stays 2; with win_ready then held high, 25 windows complete, followed by one frame_done pulse.
- data_valid toggled 1/0 during LOAD: win_valid rises exactly 1 cycle after the 25th accepted pixel; data_valid=1 held during EMIT leaves the following frame correct.
- IMG_SIZE=3, F=5, pad_mode=0, pixels 1..9: window (1,1) shows the 3x3 image in the centre surrounded by a ring of zeros; window (0,0) element 24 = 9.
- rst_n pulsed low during EMIT at window (1,3): win_valid=0 immediately; a new 25-pixel frame reloads and emits from window (0,0).
